inv_sub_bytes: RTL and testbench

INV_SUB_BYTES -- requirements
Module: inv_sub_bytes

---
 rtl/inv_sub_bytes_pkg.sv | 44 ++++
 rtl/inv_sub_bytes_if.sv | 22 ++
 rtl/inv_sub_bytes_inv_s_box.sv | 19 +
 rtl/inv_sub_bytes.sv | 100 ++++++++++
 tb/tb_inv_sub_bytes.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/inv_sub_bytes_pkg.sv
// Shared types, sizes and GF(2^8) helpers for the InvSubBytes datapath.
package inv_sub_bytes_pkg;

    localparam int unsigned NB_BYTES = 16;
    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned STATE_W  = NB_BYTES * BYTE_W;
    localparam int unsigned CNT_W    = 5;

    typedef logic [STATE_W-1:0] state_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } fsm_e;

    // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [BYTE_W-1:0] gf_mul(input logic [BYTE_W-1:0] a,
                                                 input logic [BYTE_W-1:0] b);
        logic [BYTE_W-1:0] p;
        logic [BYTE_W-1:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
    function automatic logic [BYTE_W-1:0] gf_inv(input logic [BYTE_W-1:0] a);
        logic [BYTE_W-1:0] r;
        logic [BYTE_W-1:0] p;
        r = 8'h01;
        p = a;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

endpackage

// File: rtl/inv_sub_bytes_if.sv
// Valid/ready input and output channels of the InvSubBytes block.
interface inv_sub_bytes_if;
    import inv_sub_bytes_pkg::*;

    logic   in_valid;
    logic   in_ready;
    state_t in_state;
    logic   out_valid;
    logic   out_ready;
    state_t out_state;
    logic   busy;

    modport master (
        output in_valid, in_state, out_ready,
        input  in_ready, out_valid, out_state, busy
    );

    modport slave (
        input  in_valid, in_state, out_ready,
        output in_ready, out_valid, out_state, busy
    );
endinterface

// File: rtl/inv_sub_bytes_inv_s_box.sv
// Combinational AES inverse S-box: inverse affine map followed by GF(2^8) inversion.
module inv_s_box
    import inv_sub_bytes_pkg::*;
(
    input  logic [BYTE_W-1:0] in_byte,
    output logic [BYTE_W-1:0] out_c
);

    logic [BYTE_W-1:0] aff;

    always_comb begin
        aff   = {in_byte[6:0], in_byte[7]}
              ^ {in_byte[4:0], in_byte[7:5]}
              ^ {in_byte[1:0], in_byte[7:2]}
              ^ 8'h05;
        out_c = gf_inv(aff);
    end

endmodule

// File: rtl/inv_sub_bytes.sv
// Iterative InvSubBytes: LANES bytes per cycle, MSB byte first, single result buffer.
module inv_sub_bytes
    import inv_sub_bytes_pkg::*;
#(
    parameter int unsigned LANES = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    inv_sub_bytes_if.slave bus
);

    fsm_e             state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    state_t           work_q, work_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;

    logic [BYTE_W-1:0] lane_in  [LANES];
    logic [BYTE_W-1:0] lane_out [LANES];
    logic [CNT_W-1:0]  cnt_nxt;

    // Pick the bytes at positions cnt..cnt+LANES-1 for the S-box lanes.
    always_comb begin
        for (int unsigned l = 0; l < LANES; l++) begin
            lane_in[l] = '0;
            for (int b = 0; b < NB_BYTES; b++) begin
                if (CNT_W'(b) == cnt_q + CNT_W'(l))
                    lane_in[l] = work_q[STATE_W-1-BYTE_W*b -: BYTE_W];
            end
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        inv_s_box u_inv_s_box (
            .in_byte (lane_in[g]),
            .out_c   (lane_out[g])
        );
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        cnt_nxt = cnt_q + CNT_W'(LANES);

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    work_d  = bus.in_state;
                    cnt_d   = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                for (int unsigned l = 0; l < LANES; l++) begin
                    for (int b = 0; b < NB_BYTES; b++) begin
                        if (CNT_W'(b) == cnt_q + CNT_W'(l))
                            work_d[STATE_W-1-BYTE_W*b -: BYTE_W] = lane_out[l];
                    end
                end
                cnt_d = cnt_nxt;
                if (cnt_nxt >= CNT_W'(NB_BYTES)) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (bus.out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Status outputs are registered copies of the next-state decode.
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            work_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            work_q      <= work_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_state = work_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_inv_sub_bytes.sv
// Runs LANES=1, 4 and 16 instances in lockstep against a table-driven InvSubBytes model.
module tb_inv_sub_bytes;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [127:0] in_state;
    logic         out_ready;

    int errors = 0;
    int checks = 0;

    localparam logic [7:0] FWD [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    inv_sub_bytes_if b1 ();
    inv_sub_bytes_if b4 ();
    inv_sub_bytes_if b16 ();

    inv_sub_bytes #(.LANES(1))  u_dut1  (.clk(clk), .rst_n(rst_n), .bus(b1));
    inv_sub_bytes #(.LANES(4))  u_dut4  (.clk(clk), .rst_n(rst_n), .bus(b4));
    inv_sub_bytes #(.LANES(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));

    assign b1.in_valid   = in_valid;
    assign b1.in_state   = in_state;
    assign b1.out_ready  = out_ready;
    assign b4.in_valid   = in_valid;
    assign b4.in_state   = in_state;
    assign b4.out_ready  = out_ready;
    assign b16.in_valid  = in_valid;
    assign b16.in_state  = in_state;
    assign b16.out_ready = out_ready;

    logic         ov [3];
    logic         ir [3];
    logic         bz [3];
    logic [127:0] os [3];

    always_comb begin
        ov[0] = b1.out_valid;  ir[0] = b1.in_ready;  bz[0] = b1.busy;  os[0] = b1.out_state;
        ov[1] = b4.out_valid;  ir[1] = b4.in_ready;  bz[1] = b4.busy;  os[1] = b4.out_state;
        ov[2] = b16.out_valid; ir[2] = b16.in_ready; bz[2] = b16.busy; os[2] = b16.out_state;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat_of(input int d);
        return (d == 0) ? 16 : (d == 1) ? 4 : 1;
    endfunction

    // Reference: invert each byte by searching the forward S-box table.
    function automatic logic [127:0] ref_inv(input logic [127:0] st);
        logic [127:0] r;
        logic [7:0]   v;
        r = '0;
        for (int b = 0; b < 16; b++) begin
            v = st[127-8*b -: 8];
            for (int x = 0; x < 256; x++)
                if (FWD[x] == v) r[127-8*b -: 8] = 8'(x);
        end
        return r;
    endfunction

    function automatic logic [127:0] fwd_all(input logic [127:0] st);
        logic [127:0] r;
        for (int b = 0; b < 16; b++) r[127-8*b -: 8] = FWD[st[127-8*b -: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string tag, input int d, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s lanes=%0d observed=%h expected=%h", tag, lat_of(2-d) * 0 + (16 / lat_of(d)), obs, exp);
        end
    endtask

    task automatic check_idle(input string tag, input logic [127:0] exp_os);
        for (int d = 0; d < 3; d++) begin
            chk({tag, "_out_valid"}, d, 128'(ov[d]), 128'd0);
            chk({tag, "_in_ready"},  d, 128'(ir[d]), 128'd1);
            chk({tag, "_busy"},      d, 128'(bz[d]), 128'd0);
            chk({tag, "_out_state"}, d, os[d], exp_os);
        end
    endtask

    // One accept, 20 cycles of checked BUSY/DONE with out_ready low, then handshake.
    task automatic do_txn(input logic [127:0] st, input logic [127:0] exp, input bit hold);
        in_valid = 1'b1;
        in_state = st;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                chk("txn_out_valid", d, 128'(ov[d]), 128'(k >= lat_of(d)));
                chk("txn_busy",      d, 128'(bz[d]), 128'd1);
                chk("txn_in_ready",  d, 128'(ir[d]), 128'd0);
                if (k >= lat_of(d)) chk("txn_out_state", d, os[d], exp);
            end
            if (hold && k < 18) in_state = rnd128();
            else                in_valid = 1'b0;
        end
        for (int d = 0; d < 3; d++) chk("fwd_roundtrip", d, fwd_all(os[d]), st);
        out_ready = 1'b1;
        @(negedge clk);
        check_idle("handshake", exp);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [127:0] st;
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_state  = {16{8'h63}};
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("reset", 128'd0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check_idle("post_reset", 128'd0);

        do_txn({16{8'h63}}, 128'd0, 1'b0);
        do_txn(128'h637c777bf26b6fc53001672bfed7ab76,
               128'h000102030405060708090a0b0c0d0e0f, 1'b0);
        do_txn(128'h0016_6363_6363_6363_6363_6363_6363_6363,
               128'h52ff_0000_0000_0000_0000_0000_0000_0000, 1'b0);

        for (int j = 0; j < 16; j++) begin
            for (int b = 0; b < 16; b++) st[127-8*b -: 8] = 8'(16 * j + b);
            do_txn(st, ref_inv(st), 1'b0);
        end

        for (int i = 0; i < 3; i++) begin
            st = rnd128();
            do_txn(st, ref_inv(st), 1'b1);
        end
        for (int i = 0; i < 8; i++) begin
            st = rnd128();
            do_txn(st, ref_inv(st), 1'b0);
        end

        // Reset lands on the second BUSY edge of the LANES=4 and LANES=1 instances.
        in_valid = 1'b1;
        in_state = rnd128();
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_idle("mid_reset", 128'd0);
        rst_n = 1'b1;
        st = rnd128();
        do_txn(st, ref_inv(st), 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
